// File: rtl/sp_ram_pipe_pkg.sv
// sp_ram_pipe_pkg: shared limits, response control fields and sizing helper for sp_ram_pipe
package sp_ram_pipe_pkg;
   localparam int unsigned MAX_READ_LATENCY = 4;
   typedef struct packed {
      logic valid;
      logic is_read;
      logic err;
   } rsp_ctl_t;
   function automatic int unsigned idx_width(input int unsigned words);
      return words > 1 ? $clog2(words) : 1;
   endfunction
endpackage

// File: rtl/sp_ram_pipe_dly.sv
// sp_ram_pipe_dly: fixed-depth shift register for an arbitrary payload type, synchronously cleared
module sp_ram_pipe_dly #(
   parameter int unsigned DEPTH = 1,
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  T     d,
   output T     q
);
   if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "sp_ram_pipe_dly: DEPTH must be at least 1");
   end
   T stage [DEPTH];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign q = stage[DEPTH-1];
endmodule

// File: rtl/sp_ram_pipe.sv
// sp_ram_pipe: single-port byte-enabled RAM with fixed read latency, periodic grant stall and read-data fault injection
module sp_ram_pipe
   import sp_ram_pipe_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_WORDS    = 512,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned STALL_PERIOD = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_i,
   output logic                          gnt_o,
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   input  logic                          we_i,
   input  logic [DATA_WIDTH/8-1:0]       be_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   output logic                          rvalid_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          err_o,
   input  logic                          flip_en_i,
   input  logic [$clog2(DATA_WIDTH)-1:0] flip_bit_i,
   output logic                          flip_armed_o
);
   localparam int unsigned BW    = DATA_WIDTH / 8;
   localparam int unsigned SHIFT = $clog2(BW);
   localparam int unsigned IW    = idx_width(NUM_WORDS);
   localparam int unsigned FBW   = $clog2(DATA_WIDTH);
   localparam int unsigned SCW   = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;

   if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_dw
      $fatal(1, "sp_ram_pipe: DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_rl
      $fatal(1, "sp_ram_pipe: READ_LATENCY out of range 1..%0d", MAX_READ_LATENCY);
   end
   if (STALL_PERIOD == 1) begin : g_bad_sp
      $fatal(1, "sp_ram_pipe: STALL_PERIOD of 1 would never grant");
   end
   if (NUM_WORDS < 1 || ADDR_WIDTH > 64 || ADDR_WIDTH < SHIFT + IW) begin : g_bad_geom
      $fatal(1, "sp_ram_pipe: NUM_WORDS/ADDR_WIDTH combination unsupported");
   end

   typedef struct packed {
      rsp_ctl_t              ctl;
      logic [DATA_WIDTH-1:0] data;
   } rsp_t;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
   logic [ADDR_WIDTH-1:0] idx;
   logic [IW-1:0]         widx;
   logic                  in_range;
   logic                  stall;
   logic                  accept;
   logic [SCW-1:0]        stall_cnt;
   logic                  armed;
   logic [FBW-1:0]        flip_bit;
   rsp_t                  rsp_d;
   rsp_t                  rsp_q;
   logic                  live;
   logic                  consume;

   assign idx      = addr_i >> SHIFT;
   assign widx     = idx[IW-1:0];
   assign in_range = 64'(idx) < 64'(NUM_WORDS);
   assign stall    = (STALL_PERIOD != 0) && (stall_cnt == SCW'(STALL_PERIOD - 1));
   assign gnt_o    = req_i && !stall && !rst_i;
   assign accept   = gnt_o;

   // memory deliberately has no reset so preloaded images survive rst_i
   always_ff @(posedge clk_i) begin
      if (accept && we_i && in_range)
         for (int b = 0; b < BW; b++)
            if (be_i[b]) mem[widx][8*b +: 8] <= wdata_i[8*b +: 8];
   end

   always_comb begin
      rsp_d.ctl.valid   = accept;
      rsp_d.ctl.is_read = accept && !we_i;
      rsp_d.ctl.err     = accept && !in_range;
      rsp_d.data        = (accept && !we_i && in_range) ? mem[widx] : '0;
   end

   sp_ram_pipe_dly #(
      .DEPTH (READ_LATENCY),
      .T     (rsp_t)
   ) u_dly (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d     (rsp_d),
      .q     (rsp_q)
   );

   assign live         = rsp_q.ctl.valid && !rst_i;
   assign consume      = live && armed && rsp_q.ctl.is_read && !rsp_q.ctl.err;
   assign rvalid_o     = live;
   assign err_o        = live && rsp_q.ctl.err;
   assign rdata_o      = !live ? '0 : consume ? rsp_q.data ^ (DATA_WIDTH'(1) << flip_bit) : rsp_q.data;
   assign flip_armed_o = armed && !rst_i;

   // a fresh arm request wins over consumption in the same cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         armed     <= 1'b0;
         flip_bit  <= '0;
      end else begin
         stall_cnt <= req_i ? (stall ? '0 : stall_cnt + 1'b1) : stall_cnt;
         armed     <= flip_en_i || (armed && !consume);
         flip_bit  <= flip_en_i ? flip_bit_i : flip_bit;
      end
   end
endmodule

// File: tb/tb_sp_ram_pipe.sv
// tb_sp_ram_pipe: random and directed stimulus against a queue-based reference model of sp_ram_pipe
module tb_sp_ram_pipe;
   localparam int RL = 3;
   localparam int P  = 4;
   localparam int NW = 256;

   logic        clk = 1'b0;
   logic        rst, req, gnt, we, rvalid, err, flip_en, flip_armed;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic [4:0]  flip_bit;

   int checks = 0, failures = 0, cyc = 0, resp_seen = 0;
   logic last_gnt;

   typedef struct {
      int          due;
      logic        rd;
      logic        er;
      logic [31:0] data;
   } exp_t;
   exp_t        q[$];
   logic [31:0] m_mem [NW];
   int          m_reqs = 0;
   logic        m_armed = 1'b0;
   logic [4:0]  m_bit = '0;

   always #5 clk = ~clk;

   sp_ram_pipe #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .NUM_WORDS    (NW),
      .READ_LATENCY (RL),
      .STALL_PERIOD (P)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .be_i         (be),
      .wdata_i      (wdata),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .err_o        (err),
      .flip_en_i    (flip_en),
      .flip_bit_i   (flip_bit),
      .flip_armed_o (flip_armed)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // one clock: drive, compare against the model, advance the model past the edge
   task automatic cycle(input logic rs, input logic rq, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input logic fe, input logic [4:0] fb);
      exp_t        e;
      logic        hit, g, cons;
      logic [31:0] ed;
      int          wi;
      rst = rs; req = rq; we = w; addr = a; be = b; wdata = wd; flip_en = fe; flip_bit = fb;
      g    = !rs && rq && ((m_reqs % P) != P - 1);
      hit  = !rs && q.size() > 0 && q[0].due == cyc;
      e.due = 0; e.rd = 1'b0; e.er = 1'b0; e.data = '0;
      if (hit) e = q[0];
      cons = hit && m_armed && e.rd && !e.er;
      ed   = cons ? e.data ^ (32'h1 << m_bit) : e.data;
      #1;
      if (rvalid === 1'b1) resp_seen++;
      check("gnt", gnt, g);
      check("rvalid", rvalid, hit);
      check("err", err, hit && e.er);
      check("rdata", rdata, hit ? ed : 32'h0);
      check("flip_armed", flip_armed, !rs && m_armed);
      @(posedge clk);
      #1;
      if (rs) begin
         q.delete();
         m_reqs  = 0;
         m_armed = 1'b0;
         m_bit   = '0;
      end else begin
         if (hit) void'(q.pop_front());
         if (rq) m_reqs++;
         if (g) begin
            wi = int'(a >> 2);
            e.due = cyc + RL; e.rd = !w; e.er = wi >= NW; e.data = '0;
            if (wi < NW) begin
               if (w) begin
                  for (int k = 0; k < 4; k++) if (b[k]) m_mem[wi][8*k +: 8] = wd[8*k +: 8];
               end else e.data = m_mem[wi];
            end
            q.push_back(e);
         end
         m_armed = fe || (m_armed && !cons);
         if (fe) m_bit = fb;
      end
      last_gnt = g;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
      for (int t = 0; t < 3; t++) begin
         cycle(0, 1, w, a, b, wd, 0, 0);
         if (last_gnt) return;
      end
      check("accept_bound", last_gnt, 1'b1);
   endtask

   initial begin
      int base;
      cycle(1, 1, 0, 0, 0, 0, 1, 5'd3);
      cycle(1, 1, 1, 32'h10, 4'hF, 32'h1, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      for (int w = 0; w < NW; w++) access(1, w * 4, 4'hF, $urandom);
      idle(RL + 1);
      access(1, 5 * 4, 4'hF, 32'hDEADBEEF);
      access(0, 5 * 4, 4'h0, 0);
      idle(RL + 1);
      access(1, 2 * 4, 4'hF, 32'h11223344);
      access(1, 2 * 4, 4'b0010, 32'hAABBCCDD);
      access(0, 2 * 4, 4'h0, 0);
      idle(RL + 1);
      access(0, 32'h400, 4'h0, 0);
      access(1, 32'h400, 4'hF, 32'hFFFFFFFF);
      access(0, 0, 4'h0, 0);
      access(0, 32'h3FC, 4'h0, 0);
      idle(RL + 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      base = resp_seen;
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, i * 4, 0, 0, 0, 0);
      idle(RL + 1);
      check("stall_resp_count", resp_seen - base, 6);
      cycle(0, 0, 0, 0, 0, 0, 1, 5'd0);
      access(1, 4, 4'hF, 32'h64);
      access(0, 4, 4'h0, 0);
      idle(RL + 1);
      access(0, 4, 4'h0, 0);
      idle(RL + 1);
      access(0, 8, 4'h0, 0);
      access(0, 12, 4'h0, 0);
      access(0, 16, 4'h0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      base = resp_seen;
      idle(RL + 2);
      check("post_reset_resp", resp_seen - base, 0);
      access(0, 12, 4'h0, 0);
      idle(RL + 1);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               ($urandom_range(0, NW + 15) << 2) | $urandom_range(0, 3), 4'($urandom),
               $urandom, $urandom_range(0, 15) == 0, 5'($urandom));
      idle(RL + 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
